// File: rtl/stim_pkg.sv
// Shared definitions for the stimulus channel buffer.
//  ch_idx_t     : wide channel index used for range checks on the host write port
//  MODE_STREAM  : pop-once FIFO replay
//  MODE_LOOP    : loaded sequence repeats until cleared
//  clog2_min1() : $clog2 clamped to at least 1 bit
package stim_pkg;

  typedef logic [7:0] ch_idx_t;

  localparam logic MODE_STREAM = 1'b0;
  localparam logic MODE_LOOP   = 1'b1;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stim_chan_fifo.sv
// One stimulus channel: word memory, head/tail/replay pointers, occupancy count,
// first-word-fall-through output and sticky underflow flag.
// Ports:
//  clk, rst        clock, asynchronous active-high reset
//  clear           synchronous flush of pointers, count and underflow
//  mode_loop       0 = STREAM, 1 = LOOP
//  wr_en           write strobe (already qualified by the top)
//  wr_data         word to store
//  wr_space        channel can take a word this cycle
//  out_valid       word available (count != 0)
//  out_ready       consumer takes the word
//  out_data        current word
//  underflow       sticky: out_ready seen while out_valid was low
module stim_chan_fifo
  import stim_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              mode_loop,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_space,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0] head_reg, tail_reg, rp_reg;
  logic [AW-1:0] head_next, tail_next, rp_next, rp_inc;
  logic [AW:0]   count_reg, count_next;
  logic          underflow_reg;
  logic          pop, full, is_loop;

  assign is_loop   = (mode_loop == MODE_LOOP);
  assign full      = (count_reg == CNT_FULL);
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid & out_ready;
  assign rp_inc    = rp_reg + PTR_ONE;
  assign underflow = underflow_reg;

  // A STREAM pop frees a slot in the same cycle, so a full channel can still
  // take a word alongside it. In LOOP a pop frees nothing.
  assign wr_space = !full || (!is_loop && out_ready);

  // In STREAM the replay pointer always equals head, except on the first
  // cycle after leaving LOOP; reading at head there makes the restart from
  // the oldest word visible straight away and keeps a pop on that cycle
  // consistent with the word that was presented.
  assign out_data = mem[is_loop ? rp_reg : head_reg];

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    rp_next    = rp_reg;
    count_next = count_reg;
    if (wr_en) tail_next = tail_reg + PTR_ONE;
    if (is_loop) begin
      // Replay head..tail-1 repeatedly; words stay resident.
      if (pop) rp_next = (rp_inc == tail_reg) ? head_reg : rp_inc;
      if (wr_en) count_next = count_reg + CNT_ONE;
    end else begin
      if (pop) head_next = head_reg + PTR_ONE;
      rp_next = head_next;
      if (wr_en && !pop)      count_next = count_reg + CNT_ONE;
      else if (!wr_en && pop) count_next = count_reg - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[tail_reg] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      rp_reg        <= '0;
      count_reg     <= '0;
      underflow_reg <= 1'b0;
    end else if (clear) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      rp_reg        <= '0;
      count_reg     <= '0;
      underflow_reg <= 1'b0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      rp_reg    <= rp_next;
      count_reg <= count_next;
      if (out_ready && !out_valid) underflow_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/stim_chan_buffer.sv
// Multi-channel stimulus buffer: one shared host write port fanned out to
// NUM_CH independent replay channels, plus a free-running cycle stamp.
// Ports:
//  clk, rst    clock, asynchronous active-high reset
//  mode_loop   0 = STREAM, 1 = LOOP (all channels)
//  clear       synchronous flush of all channels and sticky flags
//  wr_valid / wr_ready / wr_ch / wr_data   host write handshake
//  wr_err      sticky: write to a channel index >= NUM_CH
//  out_valid / out_ready / out_data        per-channel outputs, channel i at
//              out_data[i*DATA_W +: DATA_W]
//  underflow   per-channel sticky underflow
//  cycle       free-running cycle count
module stim_chan_buffer
  import stim_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CYC_W  = 32,
  localparam int CH_W  = clog2_min1(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode_loop,
  input  logic                     clear,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_err,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        underflow,
  output logic [CYC_W-1:0]         cycle
);

  logic [NUM_CH-1:0] space;
  logic [NUM_CH-1:0] wr_en;
  logic              sel_space;
  logic              in_range;
  logic              wr_err_reg;
  logic [CYC_W-1:0]  cycle_reg;

  assign in_range = (ch_idx_t'(wr_ch) < ch_idx_t'(NUM_CH));

  // Out-of-range indices keep sel_space at 1 so the host is never stalled
  // by a bad index; the word is simply dropped.
  always_comb begin
    sel_space = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_ch == CH_W'(i)) sel_space = space[i];
    end
    wr_ready = !clear && sel_space;
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign wr_en[gi] = wr_valid && !clear && (wr_ch == CH_W'(gi)) && space[gi];

      stim_chan_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .mode_loop (mode_loop),
        .wr_en     (wr_en[gi]),
        .wr_data   (wr_data),
        .wr_space  (space[gi]),
        .out_valid (out_valid[gi]),
        .out_ready (out_ready[gi]),
        .out_data  (out_data[gi*DATA_W +: DATA_W]),
        .underflow (underflow[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_err_reg <= 1'b0;
    end else if (clear) begin
      wr_err_reg <= 1'b0;
    end else if (wr_valid && !in_range) begin
      wr_err_reg <= 1'b1;
    end
  end

  // Cycle stamp ignores clear so timestamps stay monotonic across flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cycle_reg <= '0;
    else     cycle_reg <= cycle_reg + CYC_W'(1);
  end

  assign wr_err = wr_err_reg;
  assign cycle  = cycle_reg;

endmodule
